mod_debounce: RTL

Pushbutton input conditioner for the board's ~100 MHz PLL clock domain, and the input-side counterpart to the LED drivers. It takes one raw, asynchronous, bouncing button pin and synchronizes it into `i_clk`. It then debounces it with a counter-qualified state machine. Outputs are a clean level plus single-cycle press, release and optional long-press pulses for downstream logic such as mode selection and LED pattern control.

---
 rtl/mod_debounce_pkg.sv | 16 +
 rtl/mod_debounce_sync2.sv | 36 +++
 rtl/mod_debounce.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mod_debounce_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package pkg_debounce;

  // Debounce FSM states: stable levels and their qualification phases.
  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DN      = 2'd2,
    WAIT_UP = 2'd3
  } debounce_state_t;

  // Defaults for the ~100 MHz board PLL clock.
  localparam int unsigned DEBOUNCE_10MS_CYCLES = 1_000_000;
  localparam int unsigned LONG_1S_CYCLES       = 100_000_000;

endpackage

// File: rtl/mod_debounce_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// RST_VAL is the value both stages take during reset, so an idle
// input does not look like an event right after reset.
module mod_sync2 #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  // Next values: shift the input through the two stages.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous reset to the idle value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/mod_debounce.sv
// Pushbutton conditioner: synchronize, debounce with a counter-qualified
// FSM, and produce a clean level plus one-cycle press/release/long pulses.
// The long-press counter and o_long are built only when the macro
// DEBOUNCE_LONG_PRESS_EN is defined; otherwise o_long is tied low.
// All outputs are registered.
module mod_debounce
  import pkg_debounce::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_1S_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int unsigned    DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("mod_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("mod_debounce: LONG_PRESS_CYCLES must be >= 1");
  end

  logic btn_sync;
  logic s_pressed;

  // Idle pin value is the released level, so reset loads ACTIVE_LOW.
  mod_sync2 #(
    .W      (1),
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_btn),
    .o_q  (btn_sync)
  );

  assign s_pressed = btn_sync ^ ACTIVE_LOW;

  debounce_state_t state_q, state_d;
  logic [DCW-1:0]  cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // State register, debounce counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: any opposite sample in a WAIT state falls back to the
  // stable state; the terminal compare ends counting so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UP: begin
        if (s_pressed) begin
          state_d = WAIT_DN;
          cnt_d   = '0;
        end
      end
      WAIT_DN: begin
        if (!s_pressed)            state_d = UP;
        else if (cnt_q == DB_LAST) state_d = DN;
        else                       cnt_d   = cnt_q + DCW'(1);
      end
      DN: begin
        if (!s_pressed) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (s_pressed)             state_d = DN;
        else if (cnt_q == DB_LAST) state_d = UP;
        else                       cnt_d   = cnt_q + DCW'(1);
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pulses on accepted transitions; level is pressed in DN/WAIT_UP.
  always_comb begin
    press_d   = (state_q == WAIT_DN) &&  s_pressed && (cnt_q == DB_LAST);
    release_d = (state_q == WAIT_UP) && !s_pressed && (cnt_q == DB_LAST);
    level_d   = (state_d == DN) || (state_d == WAIT_UP);
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned    LCW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_PRESS_CYCLES - 1);
  localparam logic [LCW-1:0] LONG_SAT  = LCW'(LONG_PRESS_CYCLES);

  logic [LCW-1:0] long_cnt_q, long_cnt_d;
  logic           long_q, long_d;

  // Long counter: cleared on press, advances only in DN, held in WAIT_UP.
  // Saturating above the fire value makes o_long fire once per press.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (press_d) begin
      long_cnt_d = '0;
    end else if (state_q == DN) begin
      if (long_cnt_q == LONG_LAST) long_d = 1'b1;
      if (long_cnt_q != LONG_SAT)  long_cnt_d = long_cnt_q + LCW'(1);
    end
  end

  // Long-press counter and pulse register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = 1'b0;
`endif

endmodule
